// File: rtl/ip_hdr_parser_pipe_in_if.sv
// Signal bundle for the RX IPv4 header parser: input beat stream,
// header channel, realigned payload channel and drop counter.
interface ip_hdr_parser_pipe_in_if #(
  parameter int DATA_W = 256
);
  localparam int PADBYTES_W = $clog2(DATA_W / 8);

  // Every channel uses val/rdy: a beat transfers on a clock edge where both
  // are high; the sender holds val and payload stable until that edge.
  logic                  src_parser_data_val;
  logic [DATA_W-1:0]     src_parser_data;
  logic                  src_parser_data_last;
  logic [PADBYTES_W-1:0] src_parser_data_padbytes;
  logic                  parser_src_data_rdy;

  logic                  parser_dst_hdr_val;
  logic [31:0]           parser_dst_src_ip;
  logic [31:0]           parser_dst_dst_ip;
  logic [7:0]            parser_dst_protocol;
  logic [15:0]           parser_dst_payload_len;
  logic                  dst_parser_hdr_rdy;

  logic                  parser_dst_data_val;
  logic [DATA_W-1:0]     parser_dst_data;
  logic                  parser_dst_data_last;
  logic [PADBYTES_W-1:0] parser_dst_data_padbytes;
  logic                  dst_parser_data_rdy;

  logic [15:0]           parser_drop_cnt;
  logic [2:0]            parser_dbg_state;

  modport slave (
    input  src_parser_data_val, src_parser_data, src_parser_data_last,
           src_parser_data_padbytes, dst_parser_hdr_rdy, dst_parser_data_rdy,
    output parser_src_data_rdy, parser_dst_hdr_val, parser_dst_src_ip,
           parser_dst_dst_ip, parser_dst_protocol, parser_dst_payload_len,
           parser_dst_data_val, parser_dst_data, parser_dst_data_last,
           parser_dst_data_padbytes, parser_drop_cnt, parser_dbg_state
  );

  modport master (
    output src_parser_data_val, src_parser_data, src_parser_data_last,
           src_parser_data_padbytes, dst_parser_hdr_rdy, dst_parser_data_rdy,
    input  parser_src_data_rdy, parser_dst_hdr_val, parser_dst_src_ip,
           parser_dst_dst_ip, parser_dst_protocol, parser_dst_payload_len,
           parser_dst_data_val, parser_dst_data, parser_dst_data_last,
           parser_dst_data_padbytes, parser_drop_cnt, parser_dbg_state
  );
endinterface

// File: rtl/ip_hdr_parser_pipe_in.sv
// RX IPv4 header parser: validates a fixed 20-byte header, emits its fields,
// then forwards the payload shifted so that header byte 20 lands at byte 0.
module ip_hdr_parser_pipe_in #(
  parameter int DATA_W = 256
) (
  input logic                     clk,
  input logic                     rst,
  ip_hdr_parser_pipe_in_if.slave  bus
);
  localparam int DATA_BYTES   = DATA_W / 8;
  localparam int PADBYTES_W   = $clog2(DATA_BYTES);
  localparam int CNT_W        = PADBYTES_W + 1;
  localparam int IP_HDR_BYTES = 20;
  localparam int HDR_W        = IP_HDR_BYTES * 8;
  localparam int HOLD_BYTES   = DATA_BYTES - IP_HDR_BYTES;
  localparam int HOLD_W       = HOLD_BYTES * 8;
  localparam int HB_W         = $clog2(HOLD_BYTES + 1);

  typedef enum logic [2:0] {
    HDR_WAIT = 3'd0,
    HDR_OUT  = 3'd1,
    PAYLOAD  = 3'd2,
    DRAIN    = 3'd3,
    DROP     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HB_W-1:0]   hold_bytes_q, hold_bytes_d;
  logic              first_last_q, first_last_d;
  logic              hdr_val_q, hdr_val_d;
  logic [31:0]       src_ip_q, src_ip_d;
  logic [31:0]       dst_ip_q, dst_ip_d;
  logic [7:0]        proto_q, proto_d;
  logic [15:0]       plen_q, plen_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  beat_v;
  logic [CNT_W-1:0]  v_over_hdr;
  logic [HB_W-1:0]   first_hold_bytes;
  logic [15:0]       tot_len;
  logic [19:0]       csum_acc;
  logic [16:0]       csum_f1;
  logic [15:0]       csum_f2;
  logic              hdr_ok;
  logic              last_fits;

  assign beat_v = bus.src_parser_data_last
                ? CNT_W'(DATA_BYTES) - CNT_W'(bus.src_parser_data_padbytes)
                : CNT_W'(DATA_BYTES);
  assign v_over_hdr       = beat_v - CNT_W'(IP_HDR_BYTES);
  assign first_hold_bytes = (v_over_hdr > CNT_W'(HOLD_BYTES)) ? HB_W'(HOLD_BYTES)
                                                              : HB_W'(v_over_hdr);
  assign last_fits = (beat_v <= CNT_W'(IP_HDR_BYTES));
  assign tot_len   = bus.src_parser_data[DATA_W-17 -: 16];

  // Ones-complement sum of the ten header words; two folds absorb every carry.
  always_comb begin
    csum_acc = '0;
    for (int k = 0; k < IP_HDR_BYTES / 2; k++) begin
      csum_acc = csum_acc + 20'(bus.src_parser_data[DATA_W-1-16*k -: 16]);
    end
  end
  assign csum_f1 = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
  assign csum_f2 = csum_f1[15:0] + 16'(csum_f1[16]);

  assign hdr_ok = (bus.src_parser_data[DATA_W-1 -: 4] == 4'd4)
               && (bus.src_parser_data[DATA_W-5 -: 4] == 4'd5)
               && (tot_len >= 16'(IP_HDR_BYTES))
               && (beat_v >= CNT_W'(IP_HDR_BYTES))
               && (csum_f2 == 16'hFFFF);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_bytes_d = hold_bytes_q;
    first_last_d = first_last_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    proto_d      = proto_q;
    plen_d       = plen_q;
    drop_cnt_d   = drop_cnt_q;
    unique case (state_q)
      HDR_WAIT: begin
        if (bus.src_parser_data_val) begin
          src_ip_d     = bus.src_parser_data[DATA_W-97 -: 32];
          dst_ip_d     = bus.src_parser_data[DATA_W-129 -: 32];
          proto_d      = bus.src_parser_data[DATA_W-73 -: 8];
          plen_d       = tot_len - 16'(IP_HDR_BYTES);
          hold_d       = bus.src_parser_data[DATA_W-1-HDR_W -: HOLD_W];
          hold_bytes_d = first_hold_bytes;
          first_last_d = bus.src_parser_data_last;
          if (hdr_ok) begin
            state_d = HDR_OUT;
          end else begin
            drop_cnt_d = drop_cnt_q + 16'd1;
            if (!bus.src_parser_data_last) state_d = DROP;
          end
        end
      end
      HDR_OUT: begin
        if (bus.dst_parser_hdr_rdy) begin
          if (!first_last_q)            state_d = PAYLOAD;
          else if (hold_bytes_q == '0)  state_d = HDR_WAIT;
          else                          state_d = DRAIN;
        end
      end
      PAYLOAD: begin
        if (bus.src_parser_data_val && bus.dst_parser_data_rdy) begin
          hold_d = bus.src_parser_data[DATA_W-1-HDR_W -: HOLD_W];
          if (bus.src_parser_data_last) begin
            if (last_fits) begin
              state_d = HDR_WAIT;
            end else begin
              hold_bytes_d = HB_W'(v_over_hdr);
              state_d      = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (bus.dst_parser_data_rdy) state_d = HDR_WAIT;
      end
      DROP: begin
        if (bus.src_parser_data_val && bus.src_parser_data_last) state_d = HDR_WAIT;
      end
      default: state_d = HDR_WAIT;
    endcase
    hdr_val_d = (state_d == HDR_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDR_WAIT;
      hold_q       <= '0;
      hold_bytes_q <= '0;
      first_last_q <= 1'b0;
      hdr_val_q    <= 1'b0;
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      proto_q      <= '0;
      plen_q       <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_bytes_q <= hold_bytes_d;
      first_last_q <= first_last_d;
      hdr_val_q    <= hdr_val_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      proto_q      <= proto_d;
      plen_q       <= plen_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // In PAYLOAD the input is a straight pass-through of the output handshake.
  always_comb begin
    bus.parser_src_data_rdy      = 1'b0;
    bus.parser_dst_data_val      = 1'b0;
    bus.parser_dst_data          = '0;
    bus.parser_dst_data_last     = 1'b0;
    bus.parser_dst_data_padbytes = '0;
    unique case (state_q)
      HDR_WAIT, DROP: bus.parser_src_data_rdy = ~rst;
      PAYLOAD: begin
        bus.parser_src_data_rdy = bus.dst_parser_data_rdy & ~rst;
        bus.parser_dst_data_val = bus.src_parser_data_val;
        bus.parser_dst_data     = {hold_q, bus.src_parser_data[DATA_W-1 -: HDR_W]};
        if (bus.src_parser_data_last && last_fits) begin
          bus.parser_dst_data_last     = 1'b1;
          bus.parser_dst_data_padbytes = PADBYTES_W'(CNT_W'(IP_HDR_BYTES) - beat_v);
        end
      end
      DRAIN: begin
        bus.parser_dst_data_val      = 1'b1;
        bus.parser_dst_data          = {hold_q, {HDR_W{1'b0}}};
        bus.parser_dst_data_last     = 1'b1;
        bus.parser_dst_data_padbytes = PADBYTES_W'(CNT_W'(DATA_BYTES) - CNT_W'(hold_bytes_q));
      end
      default: ;
    endcase
  end

  assign bus.parser_dst_hdr_val     = hdr_val_q;
  assign bus.parser_dst_src_ip      = src_ip_q;
  assign bus.parser_dst_dst_ip      = dst_ip_q;
  assign bus.parser_dst_protocol    = proto_q;
  assign bus.parser_dst_payload_len = plen_q;
  assign bus.parser_drop_cnt        = drop_cnt_q;
  assign bus.parser_dbg_state       = state_q;
endmodule

// File: doc/ip_hdr_parser_pipe_in.md
Name: ip_hdr_parser_pipe_in

Overview:
- RX-side counterpart of the TX IP header assembler.
- Accepts a MAC-interface beat stream whose first bytes are an IPv4 header.
- Validates the header, emits its fields on a header val/rdy channel, then forwards the payload realigned to byte 0 on a data val/rdy channel.
- Sits between the Ethernet RX stripper and the TCP/UDP RX engines.

Parameters:
- DATA_W, `MAC_INTERFACE_W (256), beat width in bits.
- DATA_BYTES, DATA_W/8 (32), bytes per beat.
- PADBYTES_W, $clog2(DATA_BYTES) (5), width of padbytes fields.
- IP_HDR_BYTES, 20, fixed header length; options are not supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- src_parser_data_val  in  1  input beat valid
- src_parser_data  in  DATA_W  beat; byte 0 at [DATA_W-1 -: 8]
- src_parser_data_last  in  1  final beat of packet
- src_parser_data_padbytes  in  PADBYTES_W  invalid trailing bytes on last beat
- parser_src_data_rdy  out  1  input ready
- parser_dst_hdr_val  out  1  header valid
- parser_dst_src_ip  out  `IP_ADDR_W  source address
- parser_dst_dst_ip  out  `IP_ADDR_W  destination address
- parser_dst_protocol  out  `PROTOCOL_W  protocol number
- parser_dst_payload_len  out  `TOT_LEN_W  tot_len - 20
- dst_parser_hdr_rdy  in  1  header ready
- parser_dst_data_val  out  1  payload beat valid
- parser_dst_data  out  DATA_W  realigned payload
- parser_dst_data_last  out  1  final payload beat
- parser_dst_data_padbytes  out  PADBYTES_W  invalid trailing bytes
- dst_parser_data_rdy  in  1  payload ready
- parser_drop_cnt  out  16  count of dropped packets; wraps

Behaviour:
- Reset values: all val outputs and parser_src_data_rdy = 0; drop_cnt = 0; state = HDR_WAIT; hold register cleared.
- Beat V = DATA_BYTES - padbytes on a last beat, DATA_BYTES otherwise.
- HDR_WAIT:
  - rdy = 1. On accept, register header fields and bytes 20..31 into hold (12 bytes, hold_bytes = min(V-20, 12)).
  - Check: version == 4; IHL == 5; tot_len >= 20; V >= 20.
  - Check ones-complement sum of the ten 16-bit header words, end-around carries folded, == 16'hFFFF.
  - Any check fails: if not last, go to DROP; if last, stay in HDR_WAIT. drop_cnt increments in the accept cycle.
  - Pass: go to HDR_OUT.
- HDR_OUT:
  - hdr_val = 1 with registered fields; input rdy = 0. Latency: hdr_val rises 1 cycle after first-beat accept.
  - On hdr_val & hdr_rdy:
    - First beat was last with hold_bytes == 0: go to HDR_WAIT, no data beat.
    - First beat was last with hold_bytes > 0: go to DRAIN.
    - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - data_val = src_val; src rdy = dst_parser_data_rdy.
  - Output = {hold[12 B], src[bytes 0..19]}. On handshake, hold <= src bytes 20..31.
  - On a non-last beat: last = 0, padbytes = 0.
  - On a last beat with V <= 20: last = 1, padbytes = 20 - V, next state HDR_WAIT.
  - On a last beat with V > 20: last = 0 on this beat, hold_bytes = V - 20, next state DRAIN.
- DRAIN:
  - data_val = 1, data = {hold, zeros}, last = 1, padbytes = DATA_BYTES - hold_bytes; input rdy = 0.
  - On handshake, go to HDR_WAIT.
- DROP: rdy = 1, no outputs; consume beats until last is accepted, then go to HDR_WAIT.
- Ethernet min-frame trailer bytes beyond tot_len are forwarded unchanged; consumers use payload_len.
- Header and payload never overlap; the next packet's first beat is not accepted until DRAIN/PAYLOAD completes.
- Backpressure on either output stalls only that channel; all outputs hold stable while val & ~rdy.
- Async reset mid-packet: return to HDR_WAIT, discard hold, drop_cnt cleared.

Test Plan:
- Single 2-beat packet (tot_len 40, proto 6, valid checksum; beat 2 padbytes 24, V=8) -> hdr: payload_len 20, proto 6, IPs match; one data beat: 20 valid bytes = original bytes 20..39, last = 1, padbytes 12.
- 3-beat packet, last beat V=28 -> 3 data beats; third is the DRAIN beat with 8 valid bytes, padbytes 24; bytes contiguous, none lost.
- Corrupted checksum (flip one header bit), 2-beat packet -> no hdr_val, no data_val; both beats accepted; drop_cnt = 1; a following good packet parses normally.
- Single-beat packet, V=20 (tot_len 20) -> hdr_val with payload_len 0; no data beat; state returns to HDR_WAIT.
- Hold dst_parser_data_rdy low 5 cycles mid-payload, hdr_rdy low 3 cycles -> outputs stable throughout; input rdy low; final byte stream identical to the no-stall run.
- Assert rst during PAYLOAD -> all vals 0 next edge, drop_cnt 0; next packet parses correctly.
